// File: rtl/round_addr_seq_if.sv
// Bus bundle for round_addr_seq.
// The control side (AES FSM or a bench) uses the master modport. It drives
// start/dir/first/last/enable/abort and observes the address and status outputs.
// The sequencer uses the slave modport.
//   start_i       start a run (sampled in IDLE only)
//   dir_i         0 = count up, 1 = count down (latched at start)
//   first_addr_i  first counter value (latched at start)
//   last_addr_i   final counter value (latched at start)
//   enable_i      issue/advance qualifier while running; 0 = stall
//   abort_i       terminate the run without a done pulse
//   addr_o        counter minus pipeline offset
//   addr_valid_o  addr_o is issued this cycle
//   busy_o        a run is in progress
//   done_o        one-cycle pulse after the last address
//   issued_o      addresses issued in the current/last run
interface round_addr_seq_if #(
  parameter int ADDR_WIDTH = 8
);
  logic                  start_i;
  logic                  dir_i;
  logic [ADDR_WIDTH-1:0] first_addr_i;
  logic [ADDR_WIDTH-1:0] last_addr_i;
  logic                  enable_i;
  logic                  abort_i;
  logic [ADDR_WIDTH-1:0] addr_o;
  logic                  addr_valid_o;
  logic                  busy_o;
  logic                  done_o;
  logic [ADDR_WIDTH:0]   issued_o;

  modport master (
    output start_i, dir_i, first_addr_i, last_addr_i, enable_i, abort_i,
    input  addr_o, addr_valid_o, busy_o, done_o, issued_o
  );

  modport slave (
    input  start_i, dir_i, first_addr_i, last_addr_i, enable_i, abort_i,
    output addr_o, addr_valid_o, busy_o, done_o, issued_o
  );
endinterface

// File: rtl/round_addr_seq.sv
// round_addr_seq: bounded address sequencer for the AES round-key /
// instruction ROM port. It runs a counter from a latched first address to a
// latched last address, either up or down, with wrap-around modulo
// 2^ADDR_WIDTH. It supports stalls (enable_i low) and aborts, and emits a
// one-cycle done pulse after the last address. The output address lags the
// counter by PIPE_OFFSET, which keeps the ROM pipeline alignment of the
// older program counter.
// Ports:
//   clk_i  rising-edge clock
//   rst_i  asynchronous active-high reset
//   bus    round_addr_seq_if.slave (see interface header for signal list)
module round_addr_seq #(
  parameter int ADDR_WIDTH  = 8,
  parameter int PIPE_OFFSET = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  round_addr_seq_if.slave  bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [ADDR_WIDTH-1:0] OFFSET   = ADDR_WIDTH'(PIPE_OFFSET);
  localparam logic [ADDR_WIDTH-1:0] ONE      = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   ONE_WIDE = (ADDR_WIDTH + 1)'(1);

  logic [1:0]            state, state_n;
  logic [ADDR_WIDTH-1:0] cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] last_q, last_n;
  logic                  dir_q, dir_n;
  logic [ADDR_WIDTH:0]   issued, issued_n;
  logic                  issue;

  // An address is issued only while running, enabled and not aborting.
  assign issue = (state == RUN) && bus.enable_i && !bus.abort_i;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    last_n   = last_q;
    dir_n    = dir_q;
    issued_n = issued;
    case (state)
      IDLE: begin
        // abort_i takes priority over start_i.
        if (bus.start_i && !bus.abort_i) begin
          state_n  = RUN;
          cnt_n    = bus.first_addr_i;
          last_n   = bus.last_addr_i;
          dir_n    = bus.dir_i;
          issued_n = '0;
        end
      end
      RUN: begin
        if (bus.abort_i) begin
          state_n = IDLE;
        end else if (bus.enable_i) begin
          issued_n = issued + ONE_WIDE;
          // The counter holds on the last address, so addr_o stays put through DONE.
          if (cnt == last_q) begin
            state_n = DONE;
          end else if (dir_q) begin
            cnt_n = cnt - ONE;
          end else begin
            cnt_n = cnt + ONE;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state  <= IDLE;
      cnt    <= '0;
      last_q <= '0;
      dir_q  <= 1'b0;
      issued <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      last_q <= last_n;
      dir_q  <= dir_n;
      issued <= issued_n;
    end
  end

  // The subtraction wraps modulo 2^ADDR_WIDTH, so addr_o reads 2^W - OFFSET out of reset.
  assign bus.addr_o       = cnt - OFFSET;
  assign bus.addr_valid_o = issue;
  assign bus.busy_o       = (state == RUN);
  assign bus.done_o       = (state == DONE);
  assign bus.issued_o     = issued;

endmodule

// File: doc/round_addr_seq.md
Name: round_addr_seq

Overview:
- Parametrised address sequencer. Successor to the free-running program counter in the AES datapath.
- Issues a bounded run of addresses from first_addr_i to last_addr_i, counting up or down. Down-counting serves decryption round-key order.
- Supports stall, abort and a 1-cycle completion pulse.
- Keeps the fixed pipeline lag on the output address, now set by PIPE_OFFSET instead of a hard-coded 2.
- Sits between the AES control FSM and the round-key / instruction ROM address port.

Parameters:
ADDR_WIDTH, 8, width of all address ports and of the internal counter.
PIPE_OFFSET, 2, constant subtracted (mod 2^ADDR_WIDTH) from the internal counter to form addr_o; 0 = no lag.

Ports:
clk_i  input  1  clock, rising edge.
rst_i  input  1  asynchronous reset, active-high.
start_i  input  1  start a run; sampled only in IDLE.
dir_i  input  1  0 = count up, 1 = count down; latched at start.
first_addr_i  input  ADDR_WIDTH  first counter value; latched at start.
last_addr_i  input  ADDR_WIDTH  final counter value; latched at start.
enable_i  input  1  advance/issue qualifier in RUN; 0 = stall.
abort_i  input  1  terminate run, return to IDLE, no done_o.
addr_o  output  ADDR_WIDTH  cnt - PIPE_OFFSET, mod 2^ADDR_WIDTH, always driven.
addr_valid_o  output  1  addr_o is issued this cycle.
busy_o  output  1  state is RUN.
done_o  output  1  one-cycle pulse after last address issued.
issued_o  output  ADDR_WIDTH+1  number of addresses issued in current/last run.

Behaviour:
- Reset (async, rst_i=1) sets:
  - state=IDLE, cnt=0, issued_o=0.
  - Latched last/dir = 0.
  - done_o=0, busy_o=0, addr_valid_o=0.
  - addr_o = 2^ADDR_WIDTH - PIPE_OFFSET (254 at defaults).
- Reset asserted mid-run aborts immediately; no done_o.
- States: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 & abort_i=0 → latch first/last/dir, cnt<=first_addr_i, issued_o<=0, next RUN.
  - abort_i has priority over start_i.
- RUN:
  - busy_o=1.
  - addr_valid_o = enable_i & ~abort_i (combinational).
  - On clk edge with enable_i=1 & abort_i=0:
    - issued_o += 1.
    - If cnt == latched last → next DONE, cnt holds.
    - Else cnt <= cnt+1 (dir 0) or cnt-1 (dir 1), wrapping modulo 2^ADDR_WIDTH.
  - enable_i=0 → cnt, issued_o, state hold (stall, any length).
  - abort_i=1 → next IDLE; cnt and issued_o hold; no done_o.
- DONE:
  - done_o=1 for exactly this one cycle; busy_o=0; addr_valid_o=0.
  - Next IDLE unconditionally.
  - start_i in DONE is ignored; abort_i in DONE has no effect.
- Run length: (last - first) mod 2^W + 1 addresses when up; (first - last) mod 2^W + 1 when down.
  - Wrap-around is legal, e.g. up from 0xFE to 0x01 = 4 addresses.
  - first==last → exactly 1 address, then DONE.
- First issued address is available in the cycle after start_i, at the earliest.
- Minimum start-to-start spacing: run length + 2 cycles.
- issued_o holds its final value in IDLE until the next start.
- All state changes occur on the rising edge of clk_i except reset.
- Latched inputs: changes to first/last/dir during RUN have no effect.

Test Plan:
- Reset, then idle 3 cycles → addr_o=254, busy_o=0, done_o=0, issued_o=0 (defaults).
- start_i, first=0, last=10, dir=0, enable held 1 → addr_valid_o for 11 cycles; addr_o sequence 254,255,0..8; done_o 1 cycle after; issued_o=11.
- Decryption order: first=10, last=0, dir=1, PIPE_OFFSET=0 build → addr_o 10,9,...,0; done_o pulse; issued_o=11.
- Wrap: first=0xFE, last=0x01, dir=0, PIPE_OFFSET=0 → addr_o FE,FF,00,01; done_o; issued_o=4.
- Stall and abort: enable_i=0 for 3 cycles mid-run → addr_o frozen, addr_valid_o=0. Then abort_i after the 5th issue → IDLE next cycle, no done_o, issued_o=5. Start+abort together in IDLE → stays IDLE.
- Async reset asserted mid-run between clock edges → outputs return to reset values immediately; done_o never pulses.
